// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: shares one SRAM-like port between the instruction-fetch
// and data requesters, one outstanding transaction at a time.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise the data master always wins a tie.
module cpu_sram_arbiter (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t      r_state;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_mem_req;
    logic        r_mem_wr;
    logic [1:0]  r_mem_size;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_tie_data;
    logic        w_grant_data;
    logic        w_idle;

    // Tie-break: which master wins when both request in IDLE
`ifdef ARB_ROUND_ROBIN_EN
    assign w_tie_data = (r_last_grant == OWN_INST);
`else
    // Fixed priority: data wins every tie; last grant is tracked but ignored
    assign w_tie_data = r_last_grant | 1'b1;
`endif

    assign w_grant_data = data_req && (!inst_req || w_tie_data);
    assign w_idle       = resetn && (r_state == ST_IDLE);

    // Handshakes are decoded from the current state; suppressed while in reset
    assign inst_addr_ok = w_idle && inst_req && !w_grant_data;
    assign data_addr_ok = w_idle && w_grant_data;
    assign inst_data_ok = resetn && (r_state == ST_DATA) && mem_data_ok && (r_owner == OWN_INST);
    assign data_data_ok = resetn && (r_state == ST_DATA) && mem_data_ok && (r_owner == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req   = r_mem_req;
    assign mem_wr    = r_mem_wr;
    assign mem_size  = r_mem_size;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Transaction FSM: grant and latch in IDLE, present downstream in ADDR, wait in DATA
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_INST;
            r_last_grant <= OWN_INST;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_size   <= 2'd0;
            r_mem_wstrb  <= 4'd0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (inst_req || data_req) begin
                        r_state   <= ST_ADDR;
                        r_mem_req <= 1'b1;
                        if (w_grant_data) begin
                            r_owner     <= OWN_DATA;
                            r_mem_wr    <= data_wr;
                            r_mem_size  <= data_size;
                            r_mem_wstrb <= data_wstrb;
                            r_mem_addr  <= data_addr;
                            r_mem_wdata <= data_wdata;
                        end else begin
                            r_owner     <= OWN_INST;
                            r_mem_wr    <= inst_wr;
                            r_mem_size  <= inst_size;
                            r_mem_wstrb <= inst_wstrb;
                            r_mem_addr  <= inst_addr;
                            r_mem_wdata <= inst_wdata;
                        end
                    end
                end
                ST_ADDR: begin
                    if (mem_addr_ok) begin
                        r_state   <= ST_DATA;
                        r_mem_req <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (mem_data_ok) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_owner;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Scoreboard bench for cpu_sram_arbiter: a transaction-level model predicts
// grants, downstream requests and responses; a negedge monitor checks them.
module tb_cpu_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    cpu_sram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } fld_t;

    typedef struct { logic m; fld_t f; int cyc; } gexp_t;
    typedef struct { logic m; logic [31:0] rdata; int cyc; } rexp_t;

    gexp_t q_grant[$];
    gexp_t q_mem[$];
    rexp_t q_resp[$];
    logic  obs_grants[$];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    // stimulus knobs
    int   p_req[2];
    int   p_aok, p_dok, p_stray, bp_min;
    bit   fix_en[2];
    fld_t fix_f[2];
    bit   fix_rd_en;
    logic [31:0] fix_rd;

    // reference model: 0 idle, 1 request downstream, 2 awaiting response
    int   ph;
    int   wait_cnt;
    logic owner, last;
    bit   hold[2];
    fld_t cur[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Grant rule from the arbitration policy: returns 1 when data wins
    function automatic logic pick(input bit ir, input bit dr);
        if (!dr) return 1'b0;
        if (!ir) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return (last == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic fld_t rand_fld();
        fld_t f;
        f.wr    = 1'($urandom);
        f.size  = 2'($urandom_range(0, 2));
        f.wstrb = 4'($urandom);
        f.addr  = $urandom;
        f.wdata = $urandom;
        return f;
    endfunction

    task automatic drive_masters();
        inst_req = hold[0];
        data_req = hold[1];
        {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata} = cur[0];
        {data_wr, data_size, data_wstrb, data_addr, data_wdata} = cur[1];
    endtask

    // One clock of stimulus plus the model's prediction for that clock
    task automatic do_cycle();
        logic w;
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            if (!hold[m] && ($urandom % 100) < p_req[m]) begin
                hold[m] = 1'b1;
                cur[m]  = fix_en[m] ? fix_f[m] : rand_fld();
            end
        end
        drive_masters();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (ph == 1) begin
            wait_cnt++;
            if (wait_cnt > bp_min && ($urandom % 100) < p_aok) mem_addr_ok = 1'b1;
        end else if (ph == 2) begin
            if (($urandom % 100) < p_dok) mem_data_ok = 1'b1;
        end
        if (ph != 2 && ($urandom % 100) < p_stray) mem_data_ok = 1'b1;
        mem_rdata = fix_rd_en ? fix_rd : $urandom;
        if (ph == 0) begin
            if (hold[0] || hold[1]) begin
                w = pick(hold[0], hold[1]);
                q_grant.push_back('{m: w, f: cur[w], cyc: cyc});
                q_mem.push_back('{m: w, f: cur[w], cyc: cyc + 1});
                owner = w;
                hold[w] = 1'b0;
                ph = 1;
                wait_cnt = 0;
            end
        end else if (ph == 1) begin
            if (mem_addr_ok) ph = 2;
        end else begin
            if (mem_data_ok) begin
                q_resp.push_back('{m: owner, rdata: mem_rdata, cyc: cyc});
                last = owner;
                ph = 0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle();
    endtask

    task automatic one_shot(input int m);
        p_req[m] = 100;
        do_cycle();
        p_req[m] = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        p_req[0] = 0;
        p_req[1] = 0;
        p_aok = 100;
        while ((ph != 0 || hold[0] || hold[1]) && n < 200) begin
            do_cycle();
            n++;
        end
        if (ph != 0 || hold[0] || hold[1]) fail_now("drain_timeout");
        run(2);
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake
    logic prev_req = 1'b0;
    fld_t prev_f;
    always @(negedge clk) begin : mon
        gexp_t g;
        rexp_t r;
        fld_t  mf;
        if (!resetn) begin
            prev_req = 1'b0;
        end else begin
            mf = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
            if (inst_addr_ok && data_addr_ok) begin
                fail_now("addr_ok_both");
            end else if (inst_addr_ok || data_addr_ok) begin
                if (q_grant.size() == 0) fail_now("spurious_addr_ok");
                else begin
                    g = q_grant.pop_front();
                    chk("grant_master", 72'(data_addr_ok), 72'(g.m));
                    chk("grant_cycle", 72'(cyc), 72'(g.cyc));
                    obs_grants.push_back(data_addr_ok);
                end
            end
            if (mem_req && !prev_req) begin
                if (q_mem.size() == 0) fail_now("spurious_mem_req");
                else begin
                    g = q_mem.pop_front();
                    chk("mem_fields", 72'(mf), 72'(g.f));
                    chk("mem_req_cycle", 72'(cyc), 72'(g.cyc));
                end
            end else if (mem_req) begin
                chk("mem_fields_stable", 72'(mf), 72'(prev_f));
                chk("addr_ok_while_busy", 72'(inst_addr_ok | data_addr_ok), 72'(0));
            end
            if (inst_data_ok && data_data_ok) begin
                fail_now("data_ok_both");
            end else if (inst_data_ok || data_data_ok) begin
                if (q_resp.size() == 0) fail_now("spurious_data_ok");
                else begin
                    r = q_resp.pop_front();
                    chk("resp_master", 72'(data_data_ok), 72'(r.m));
                    chk("resp_rdata", 72'(data_data_ok ? data_rdata : inst_rdata), 72'(r.rdata));
                    chk("resp_cycle", 72'(cyc), 72'(r.cyc));
                end
            end
            prev_req = mem_req;
            prev_f   = mf;
        end
    end

    task automatic model_reset();
        ph = 0;
        wait_cnt = 0;
        owner = 1'b0;
        last = 1'b0;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        q_grant.delete();
        q_mem.delete();
        q_resp.delete();
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_mem_req"}, 72'(mem_req), 72'(0));
        chk({tag, "_mem_fields"}, 72'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}), 72'(0));
        chk({tag, "_addr_ok"}, 72'({inst_addr_ok, data_addr_ok}), 72'(0));
        chk({tag, "_data_ok"}, 72'({inst_data_ok, data_data_ok}), 72'(0));
    endtask

    initial begin : main
        logic exp_g[3];
        int base, n;
        p_req[0] = 0; p_req[1] = 0;
        p_aok = 100; p_dok = 100; p_stray = 0; bp_min = 0;
        fix_en[0] = 1'b0; fix_en[1] = 1'b0; fix_rd_en = 1'b0; fix_rd = 32'h0;
        fix_f[0] = '0; fix_f[1] = '0;
        cur[0] = '0; cur[1] = '0;
        model_reset();
        // hold requests and a response pulse high during reset: none may leak through
        resetn = 1'b0;
        drive_masters();
        inst_req = 1'b1; data_req = 1'b1;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_in_reset("reset");
        @(posedge clk); #1;
        drive_masters();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;

        // single instruction read
        fix_en[0] = 1'b1;
        fix_f[0]  = '{wr: 1'b0, size: 2'd2, wstrb: 4'hF, addr: 32'hBFC00000, wdata: 32'h0};
        fix_rd_en = 1'b1; fix_rd = 32'h12345678;
        one_shot(0);
        run(4);
        fix_en[0] = 1'b0; fix_rd_en = 1'b0;

        // contention: both masters request continuously for three grants
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1;
`else
        exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b1;
`endif
        base = obs_grants.size();
        p_req[0] = 100; p_req[1] = 100;
        n = 0;
        while (obs_grants.size() < base + 3 && n < 100) begin
            do_cycle();
            @(negedge clk); #1;
            n++;
        end
        p_req[0] = 0; p_req[1] = 0;
        if (obs_grants.size() < base + 3) fail_now("contention_timeout");
        else begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("contention_grant%0d", k), 72'(obs_grants[base + k]), 72'(exp_g[k]));
        end
        drain();

        // byte write
        fix_en[1] = 1'b1;
        fix_f[1]  = '{wr: 1'b1, size: 2'd0, wstrb: 4'b0010, addr: 32'h1FAF0001, wdata: 32'h0000AB00};
        p_dok = 50;
        one_shot(1);
        drain();
        fix_en[1] = 1'b0;

        // backpressure: downstream refuses the address for 5 cycles
        bp_min = 5;
        one_shot(0);
        drain();
        bp_min = 0;

        // stray responses in IDLE and in ADDR
        p_stray = 100;
        run(3);
        bp_min = 3;
        p_dok = 100;
        one_shot(1);
        drain();
        bp_min = 0;
        p_stray = 0;

        // randomized traffic
        p_req[0] = 30; p_req[1] = 30;
        p_aok = 60; p_dok = 50; p_stray = 10;
        run(400);
        p_stray = 0;
        drain();

        // reset while awaiting the response
        p_dok = 0; p_aok = 100;
        one_shot(0);
        n = 0;
        while (ph != 2 && n < 20) begin
            do_cycle();
            n++;
        end
        if (ph != 2) fail_now("reach_data_timeout");
        run(1);
        @(posedge clk); #1;
        resetn = 1'b0;
        inst_req = 1'b1; data_req = 1'b1; mem_data_ok = 1'b1;
        #1;
        check_in_reset("midreset");
        model_reset();
        @(posedge clk); #1;
        drive_masters();
        mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        p_dok = 100;
        one_shot(0);
        run(4);
        drain();

        chk("left_grants", 72'(q_grant.size()), 72'(0));
        chk("left_mem", 72'(q_mem.size()), 72'(0));
        chk("left_resp", 72'(q_resp.size()), 72'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
